// File: rtl/cpu_state_tx_pkg.sv
// Shared types and constants for the CPU state debug transmitter.
package cpu_state_tx_pkg;

   typedef enum logic {IDLE, SEND} state_t;

   localparam int         FRAME_LEN      = 19;
   localparam logic [4:0] IDX_HDR        = 5'd0;
   localparam logic [4:0] IDX_FLAGS      = 5'd17;
   localparam logic [4:0] IDX_CSUM       = 5'd18;
   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

   // 130-bit architectural snapshot; regs[0] is Reg0
   typedef struct packed {
      logic [7:0][15:0] regs;
      logic             zero;
      logic             carry;
   } snap_t;

endpackage

// File: rtl/cpu_state_byte_sel.sv
// Combinational frame byte mux: picks header, register byte, flags or checksum by index.
module cpu_state_byte_sel
   import cpu_state_tx_pkg::*;
#(
   parameter logic [7:0] HEADER = HEADER_DEFAULT
)
(
   input  snap_t      snap,
   input  logic [4:0] idx,
   input  logic [7:0] csum,
   output logic [7:0] tx_byte
);

   logic [3:0]  reg_pos;
   logic [15:0] word;

   // idx 1..16 maps to reg_pos 0..15; idx 16 wraps idx[3:0]=0 to 15
   always_comb begin
      reg_pos = idx[3:0] - 4'd1;
      word    = snap.regs[reg_pos[3:1]];
      tx_byte = 8'h00;
      if (idx == IDX_HDR)
         tx_byte = HEADER;
      else if (idx < IDX_FLAGS)
         tx_byte = reg_pos[0] ? word[7:0] : word[15:8];
      else if (idx == IDX_FLAGS)
         tx_byte = {6'b0, snap.zero, snap.carry};
      else if (idx == IDX_CSUM)
         tx_byte = csum;
   end

endmodule

// File: rtl/cpu_state_tx.sv
// Snapshots CPU registers and flags on a trigger (or on change) and streams a
// 19-byte frame over a valid/ready byte interface.
module cpu_state_tx
   import cpu_state_tx_pkg::*;
#(
   parameter logic [7:0] HEADER         = HEADER_DEFAULT,
   parameter bit         AUTO_ON_CHANGE = 1'b1
)
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [15:0] Reg0,
   input  logic [15:0] Reg1,
   input  logic [15:0] Reg2,
   input  logic [15:0] Reg3,
   input  logic [15:0] Reg4,
   input  logic [15:0] Reg5,
   input  logic [15:0] Reg6,
   input  logic [15:0] Reg7,
   input  logic        Current_Zero,
   input  logic        Current_Carry,
   input  logic        TRIG,
   output logic [7:0]  TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   output logic        BUSY,
   output logic [7:0]  DROP_CNT
);

   state_t     state, state_nxt;
   snap_t      snap, live;
   logic [4:0] idx;
   logic [7:0] csum, cur_byte;
   logic       pend, auto_chg, start, hs, last_hs;

   always_comb begin
      live.regs[0] = Reg0;
      live.regs[1] = Reg1;
      live.regs[2] = Reg2;
      live.regs[3] = Reg3;
      live.regs[4] = Reg4;
      live.regs[5] = Reg5;
      live.regs[6] = Reg6;
      live.regs[7] = Reg7;
      live.zero    = Current_Zero;
      live.carry   = Current_Carry;
   end

   assign auto_chg = AUTO_ON_CHANGE && (live != snap);
   assign start    = (state == IDLE) && (TRIG || pend || auto_chg);
   assign hs       = (state == SEND) && TX_READY;
   assign last_hs  = hs && (idx == IDX_CSUM);

   cpu_state_byte_sel #(.HEADER(HEADER)) u_byte_sel (
      .snap    (snap),
      .idx     (idx),
      .csum    (csum),
      .tx_byte (cur_byte)
   );

   always_comb begin
      state_nxt = state;
      TX_VALID  = 1'b0;
      BUSY      = 1'b0;
      TX_DATA   = 8'h00;
      if (state == IDLE) begin
         if (start) state_nxt = SEND;
      end else begin
         TX_VALID = 1'b1;
         BUSY     = 1'b1;
         TX_DATA  = cur_byte;
         if (last_hs) state_nxt = IDLE;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         snap     <= '0;
         idx      <= IDX_HDR;
         csum     <= 8'h00;
         pend     <= 1'b0;
         DROP_CNT <= 8'h00;
      end else begin
         state <= state_nxt;
         if (start) begin
            snap <= live;
            idx  <= IDX_HDR;
            csum <= 8'h00;
            pend <= 1'b0;
         end else if (state == SEND) begin
            if (hs) begin
               csum <= csum ^ cur_byte;
               if (!last_hs) idx <= idx + 5'd1;
            end
            // one request is parked in pend; any further trigger is counted as dropped
            if (TRIG && pend && (DROP_CNT != 8'hFF))
               DROP_CNT <= DROP_CNT + 8'd1;
            if (TRIG || auto_chg)
               pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_state_tx.sv
// Bench for cpu_state_tx: one instance with auto-change off, one with it on.
module tb_cpu_state_tx;
   logic        clk;
   logic        rst_n0, rst_n1;
   logic [15:0] r [8];
   logic        zf, cf;
   logic        trig0, trig1, ready0, ready1;
   logic [7:0]  data0, data1, drop0, drop1;
   logic        valid0, valid1, busy0, busy1;

   int checks = 0;
   int failures = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   cpu_state_tx #(.HEADER(8'hA5), .AUTO_ON_CHANGE(1'b0)) dut0 (
      .CLK(clk), .RST_N(rst_n0),
      .Reg0(r[0]), .Reg1(r[1]), .Reg2(r[2]), .Reg3(r[3]),
      .Reg4(r[4]), .Reg5(r[5]), .Reg6(r[6]), .Reg7(r[7]),
      .Current_Zero(zf), .Current_Carry(cf), .TRIG(trig0),
      .TX_DATA(data0), .TX_VALID(valid0), .TX_READY(ready0),
      .BUSY(busy0), .DROP_CNT(drop0)
   );

   cpu_state_tx #(.HEADER(8'hA5), .AUTO_ON_CHANGE(1'b1)) dut1 (
      .CLK(clk), .RST_N(rst_n1),
      .Reg0(r[0]), .Reg1(r[1]), .Reg2(r[2]), .Reg3(r[3]),
      .Reg4(r[4]), .Reg5(r[5]), .Reg6(r[6]), .Reg7(r[7]),
      .Current_Zero(zf), .Current_Carry(cf), .TRIG(trig1),
      .TX_DATA(data1), .TX_VALID(valid1), .TX_READY(ready1),
      .BUSY(busy1), .DROP_CNT(drop1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // expected frame from the current inputs; optional fixed checksum from the table
   task automatic push_frame(input int k, input bit use_c, input logic [7:0] c_in);
      logic [7:0] b [19];
      logic [7:0] x;
      b[0] = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         b[1 + 2*i] = r[i][15:8];
         b[2 + 2*i] = r[i][7:0];
      end
      b[17] = {6'b0, zf, cf};
      x = 8'h00;
      for (int i = 0; i < 18; i++) x = x ^ b[i];
      b[18] = use_c ? c_in : x;
      for (int i = 0; i < 19; i++) begin
         if (k == 0) q0.push_back(b[i]);
         else        q1.push_back(b[i]);
      end
   endtask

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   task automatic drain(input int k);
      int n = 0;
      while (qsize(k) != 0 && n < 400) begin
         step();
         n++;
      end
      if (n >= 400) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout%0d actual=%0d bytes left required=0", k, qsize(k));
      end
   endtask

   task automatic idle_check(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check((k == 0) ? "idle_valid0" : "idle_valid1", (k == 0) ? valid0 : valid1, 0);
      end
   endtask

   // scoreboard monitors: sample at negedge, compare each accepted byte
   int pos0 = 0, pos1 = 0;
   logic stall0 = 0, stall1 = 0, last0 = 0, last1 = 0;
   logic [7:0] held0 = 0, held1 = 0;

   always @(negedge clk) begin
      if (!rst_n0) begin
         pos0 = 0; stall0 = 0; last0 = 0;
      end else begin
         if (last0) check("gap0", valid0, 0);
         if (stall0) begin
            check("hold_valid0", valid0, 1);
            check("hold_data0", data0, held0);
         end
         last0 = 0;
         if (valid0 && ready0) begin
            if (q0.size() == 0) check("unexpected_byte0", data0, 32'hFFFF_FFFF);
            else check("byte0", data0, q0.pop_front());
            pos0 = (pos0 == 18) ? 0 : pos0 + 1;
            last0 = (pos0 == 0);
         end
         stall0 = valid0 && !ready0;
         held0  = data0;
      end
   end

   always @(negedge clk) begin
      if (!rst_n1) begin
         pos1 = 0; stall1 = 0; last1 = 0;
      end else begin
         if (last1) check("gap1", valid1, 0);
         if (stall1) begin
            check("hold_valid1", valid1, 1);
            check("hold_data1", data1, held1);
         end
         last1 = 0;
         if (valid1 && ready1) begin
            if (q1.size() == 0) check("unexpected_byte1", data1, 32'hFFFF_FFFF);
            else check("byte1", data1, q1.pop_front());
            pos1 = (pos1 == 18) ? 0 : pos1 + 1;
            last1 = (pos1 == 0);
         end
         stall1 = valid1 && !ready1;
         held1  = data1;
      end
   end

   typedef struct packed {
      logic [7:0][15:0] regs;
      logic             z;
      logic             c;
      bit               rnd;
      logic [7:0]       csum;
   } vec_t;

   vec_t vt [6];

   initial begin
      int cyc;
      for (int i = 0; i < 8; i++) begin
         vt[0].regs[i] = 16'((i + 1) * 16'h1111);
         vt[1].regs[i] = 16'h0000;
         vt[2].regs[i] = 16'hFFFF;
         vt[3].regs[i] = (i == 0) ? 16'h1234 : 16'h0000;
         vt[4].regs[i] = 16'(i + 1);
         vt[5].regs[i] = 16'((i + 1) * 16'h1111);
      end
      vt[0].z = 1; vt[0].c = 0; vt[0].rnd = 0; vt[0].csum = 8'hA7;
      vt[1].z = 0; vt[1].c = 0; vt[1].rnd = 1; vt[1].csum = 8'hA5;
      vt[2].z = 1; vt[2].c = 1; vt[2].rnd = 0; vt[2].csum = 8'hA6;
      vt[3].z = 0; vt[3].c = 1; vt[3].rnd = 1; vt[3].csum = 8'h82;
      vt[4].z = 0; vt[4].c = 0; vt[4].rnd = 1; vt[4].csum = 8'hAD;
      vt[5].z = 1; vt[5].c = 0; vt[5].rnd = 1; vt[5].csum = 8'hA7;

      rst_n0 = 0; rst_n1 = 0;
      for (int i = 0; i < 8; i++) r[i] = 16'h0;
      zf = 0; cf = 0; trig0 = 0; trig1 = 0; ready0 = 1; ready1 = 1;
      step(); step();
      check("rst_valid0", valid0, 0);
      check("rst_busy0", busy0, 0);
      check("rst_data0", data0, 0);
      check("rst_drop0", drop0, 0);
      rst_n0 = 1;
      step();

      // table-driven frames on the trigger-only instance
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < 8; i++) r[i] = vt[e].regs[i];
         zf = vt[e].z; cf = vt[e].c;
         push_frame(0, 1'b1, vt[e].csum);
         trig0 = 1; ready0 = 1;
         check("pre_trig_valid0", valid0, 0);
         step();
         trig0 = 0;
         check("latency_valid0", valid0, 1);
         check("latency_busy0", busy0, 1);
         check("latency_hdr0", data0, 8'hA5);
         cyc = 0;
         while (valid0 && cyc < 200) begin
            ready0 = vt[e].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            cyc++;
         end
         ready0 = 1;
         if (!vt[e].rnd) check("frame_cycles0", cyc, 19);
         check("frame_complete0", q0.size(), 0);
         step();
      end
      check("drop_after_table0", drop0, 0);

      // snapshot isolation without auto-change: one frame, old Reg3
      push_frame(0, 1'b0, 8'h00);
      trig0 = 1; step(); trig0 = 0;
      for (int i = 0; i < 5; i++) step();
      r[3] = 16'hDEAD;
      drain(0);
      idle_check(0, 5);
      r[3] = 16'h4444;

      // four triggers during a frame: one follow-on frame, three drops
      push_frame(0, 1'b0, 8'h00);
      push_frame(0, 1'b0, 8'h00);
      trig0 = 1; step();
      for (int i = 0; i < 12; i++) begin
         trig0 = (i == 2 || i == 4 || i == 6 || i == 8);
         step();
      end
      trig0 = 0;
      drain(0);
      idle_check(0, 4);
      check("drop_count0", drop0, 3);

      // flood triggers while stalled: counter saturates
      push_frame(0, 1'b0, 8'h00);
      push_frame(0, 1'b0, 8'h00);
      ready0 = 0; trig0 = 1;
      for (int i = 0; i < 301; i++) step();
      trig0 = 0;
      check("drop_saturate0", drop0, 8'hFF);
      ready0 = 1;
      drain(0);
      idle_check(0, 4);

      // reset while byte 7 is presented
      push_frame(0, 1'b0, 8'h00);
      trig0 = 1; step(); trig0 = 0;
      for (int i = 0; i < 7; i++) step();
      check("pre_reset_valid0", valid0, 1);
      rst_n0 = 0;
      #1;
      check("async_rst_valid0", valid0, 0);
      check("async_rst_busy0", busy0, 0);
      check("async_rst_drop0", drop0, 0);
      check("async_rst_data0", data0, 0);
      q0.delete();
      step(); step();
      rst_n0 = 1;
      idle_check(0, 10);
      push_frame(0, 1'b0, 8'h00);
      trig0 = 1; step(); trig0 = 0;
      drain(0);
      idle_check(0, 3);

      // auto-change instance: nonzero input out of reset gives exactly one frame
      for (int i = 0; i < 8; i++) r[i] = 16'h0;
      zf = 0; cf = 0;
      r[7] = 16'h0001;
      push_frame(1, 1'b1, 8'hA4);
      step();
      rst_n1 = 1;
      check("auto_rst_valid1", valid1, 0);
      drain(1);
      idle_check(1, 20);

      // live change mid-frame: frame keeps old Reg3, then a DEAD frame follows
      for (int i = 0; i < 8; i++) r[i] = 16'((i + 1) * 16'h1111);
      zf = 1; cf = 0;
      push_frame(1, 1'b0, 8'h00);
      step(); step(); step(); step();
      r[3] = 16'hDEAD;
      push_frame(1, 1'b0, 8'h00);
      drain(1);
      idle_check(1, 5);
      check("auto_no_drop1", drop1, 0);

      // trigger coinciding with a change in IDLE yields a single frame
      r[0] = 16'hBEEF;
      trig1 = 1;
      push_frame(1, 1'b0, 8'h00);
      step();
      trig1 = 0;
      drain(1);
      idle_check(1, 5);
      check("merge_drop1", drop1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_state_tx.md
# cpu_state_tx

Debug transmitter that snapshots the 16-bit RISC core's architectural state (Reg0..Reg7, zero and carry flags) and streams it out as a fixed 19-byte frame over a valid/ready byte interface. It sits beside the CPU top, consuming its register and flag outputs, and feeds a byte sink such as a UART or a trace FIFO. Snapshots are taken on an explicit trigger, or optionally whenever the observed state changes.

## Interface
- HEADER, 8'hA5, first byte of every frame
- AUTO_ON_CHANGE, 1, when 1 an internal trigger fires whenever the inputs differ from the last captured snapshot
- CLK  in  1  rising-edge clock, same domain as the CPU
- RST_N  in  1  reset; one clock, reset is asynchronous and active-low
- Reg0..Reg7  in  16 each  architectural registers from the CPU
- Current_Zero  in  1  zero flag
- Current_Carry  in  1  carry flag
- TRIG  in  1  single-cycle snapshot request
- TX_DATA  out  8  frame byte
- TX_VALID  out  1  TX_DATA holds a valid byte
- TX_READY  in  1  sink accepts the byte on VALID&READY
- BUSY  out  1  frame in progress
- DROP_CNT  out  8  saturating count of discarded triggers

## Operation
- Frame byte index 0..18:
  - 0: HEADER
  - 1..16: Reg0..Reg7, each high byte then low byte
  - 17: {6'b0, Z, C}
  - 18: XOR of bytes 0..17
- FSM states:
  - IDLE: if TRIG, PEND or an auto-change is seen, capture all inputs into the snapshot register, clear PEND, set idx=0, go to SEND.
  - SEND: TX_VALID=1 and TX_DATA=byte[idx]. On handshake at idx<18, idx increments. On handshake at idx=18, go to IDLE.
- Frame content comes only from the snapshot. Input changes during SEND do not affect the frame in flight.
- Trigger during SEND, or on the final-handshake cycle: sets PEND if clear; otherwise DROP_CNT increments and saturates at 255.
- Auto-change during SEND sets PEND and never increments DROP_CNT.
- Auto-change compares the live inputs against the snapshot, 130 bits.
- After reset the snapshot is 0. Nonzero inputs after reset therefore trigger a frame when AUTO_ON_CHANGE=1.
- Checksum accumulates as bytes are presented and resets to 0 at each capture. A fresh recompute is also acceptable; only the value must match.

## Timing
- Reset values: TX_VALID=0, TX_DATA=0, BUSY=0, DROP_CNT=0, PEND=0, snapshot=0, state IDLE.
- Capture happens on the edge where IDLE sees a trigger. TX_VALID=1 with HEADER on the next cycle, so latency is 1 cycle.
- BUSY is asserted whenever state is SEND.
- While TX_VALID=1 and TX_READY=0, TX_DATA is held stable. TX_VALID never drops before a handshake.
- With TX_READY held at 1, a frame occupies exactly 19 consecutive cycles.
- After the final handshake there is at least one IDLE cycle (TX_VALID=0) before the next frame's header.
- Reset asserted mid-frame aborts immediately: outputs take reset values asynchronously, and no remaining bytes are sent.
- TRIG and an auto-change in the same IDLE cycle produce one frame only.

## Structure
- Shared package `cpu_state_tx_pkg` holds:
  - state enum {IDLE, SEND}
  - FRAME_LEN=19
  - index constants IDX_HDR=0, IDX_FLAGS=17, IDX_CSUM=18
  - default HEADER value
- Sub-module `cpu_state_byte_sel`: a combinational mux from {snapshot, idx, checksum} to the byte. It is reusable by a future trace-FIFO path.

## Test plan
- **Basic frame.** Reset, AUTO_ON_CHANGE=0, Reg0..Reg7=16'h1111..16'h8888, Z=1, C=0, pulse TRIG, TX_READY=1. Expect 19 bytes: A5, 11 11, 22 22 … 88 88, 02, then checksum A7. TX_VALID appears 1 cycle after TRIG.
- **Backpressure.** Toggle TX_READY in a random pattern. Expect TX_DATA stable while stalled, no byte lost or duplicated, and an identical byte sequence.
- **Snapshot isolation.** Change Reg3 to 16'hDEAD mid-frame. Expect the frame to still show the old Reg3. With AUTO_ON_CHANGE=1, expect a second frame with DE AD after an IDLE gap.
- **Trigger overflow.** Pulse TRIG 4 times during a frame. Expect exactly one follow-on frame and DROP_CNT=3. Further flooding saturates at 255.
- **Reset mid-frame.** Assert RST_N=0 at byte 7. Expect TX_VALID=0, BUSY=0, DROP_CNT=0 immediately. After release with AUTO_ON_CHANGE=0, expect no output until TRIG.
- **Auto-change from reset.** AUTO_ON_CHANGE=1, Reg7=16'h0001. Expect one frame automatically and none further while inputs stay constant.
